reg_file_slave: RTL
===================

// Module: reg_file_slave
// PURPOSE
// - Register-bank responder for the reg_if protocol: terminates the slave side of reg_if.
// - Holds NUM_REGS registers of DATA_WIDTH bits, serves master writes and reads, and
//   exports all register contents as a flat vector to the rest of the design.
// - One outstanding write and one outstanding read; the channels operate independently.
// PARAMETERS
// - ADDR_WIDTH   5        register address width
// - DATA_WIDTH   32       register data width
// - NUM_REGS     32       implemented registers, 1..2**ADDR_WIDTH; addresses >= NUM_REGS are unmapped
// - RESET_VALUE  '0       reset value of every register
// - RO_MASK      '0       NUM_REGS-bit mask; bit i = 1 makes register i read-only to the master
// PORTS
// - clk       in   1                      clock; all logic on its rising edge
// - rst_n     in   1                      asynchronous, active-low reset
// - waddr     in   ADDR_WIDTH             write address
// - wdata     in   DATA_WIDTH             write data
// - wvalid    in   1                      write request valid
// - wready    out  1                      slave can accept a write
// - bready    in   1                      master can accept a write response
// - bdata     out  DATA_WIDTH             write response: register value after the write
// - bvalid    out  1                      write response valid
// - raddr     in   ADDR_WIDTH             read address
// - arvalid   in   1                      read address valid
// - aready    out  1                      slave can accept a read address
// - rdata     out  DATA_WIDTH             read data
// - rvalid    out  1                      read data valid
// - rready    in   1                      master can accept read data
// - regs_o    out  NUM_REGS*DATA_WIDTH    register contents; register i at [i*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
// - Reset (rst_n low, takes effect asynchronously): all registers = RESET_VALUE; bvalid = 0, rvalid = 0,
//   bdata = 0, rdata = 0. wready = 1 and aready = 1 as soon as reset deasserts.
// - Any transaction in flight when reset asserts is dropped; no response is produced after reset.
// - Write FSM states: W_IDLE and W_RESP.
//   - W_IDLE: wready = 1. When wvalid & wready is sampled, the FSM updates the register at the same
//     edge, loads bdata with the post-write value, and goes to W_RESP.
//   - W_RESP: wready = 0, bvalid = 1. bdata is held stable. When bvalid & bready is sampled, the FSM
//     returns to W_IDLE; wready goes high the next cycle (no write-to-write bypass).
//   - Latency: the write is accepted at edge N, bvalid is high from N+1, and regs_o reflects the
//     new value from N+1.
// - Read FSM states: R_IDLE and R_RESP.
//   - R_IDLE: aready = 1. When arvalid & aready is sampled, rdata is loaded with the register
//     contents and the FSM goes to R_RESP.
//   - R_RESP: aready = 0, rvalid = 1, rdata is held. On rvalid & rready the FSM returns to R_IDLE.
//   - Latency: address accepted at edge N, rvalid is high from N+1.
// - Read-only registers (RO_MASK[i] = 1): the write handshake and response complete normally;
//   the register is unchanged and bdata returns the unchanged value.
// - Unmapped address (>= NUM_REGS): the write is dropped with bdata = 0; a read returns rdata = 0.
//   Both handshakes still complete.
// - A read and a write to the same address accepted on the same edge: the read returns the
//   pre-write value (read-before-write). The write takes effect normally.
// - wvalid or arvalid may drop before the handshake completes; nothing is captured without the
//   handshake. Inputs are only sampled in the handshake cycle.
// - The write and read channels never stall each other. Both may complete on the same cycle.
// TESTING
// - Reset: rst_n low mid-W_RESP with bvalid = 1 -> bvalid = 0 and rvalid = 0 immediately,
//   all regs_o = RESET_VALUE, wready = aready = 1 after release.
// - Write then read: write waddr = 3, wdata = 0xDEADBEEF -> bvalid on the next cycle with
//   bdata = 0xDEADBEEF. Then read raddr = 3 -> rdata = 0xDEADBEEF one cycle after acceptance.
// - Backpressure: hold bready = 0 for 5 cycles -> bvalid and bdata are stable and wready = 0
//   throughout. Hold rready = 0 for 4 cycles -> rdata is stable and aready = 0.
// - RO/unmapped: with RO_MASK[1] = 1, write 0x55 to addr 1 -> bdata = RESET_VALUE and reg 1 is
//   unchanged. With NUM_REGS = 8, write to addr 9 -> bdata = 0; read addr 9 -> rdata = 0.
// - Collision: write 0x1234 and read of addr 2 (old value 0xAAAA) accepted on the same edge ->
//   rdata = 0xAAAA, bdata = 0x1234; a later read of addr 2 returns 0x1234.
// - Random back-to-back traffic against a reference model with randomized bready/rready ->
//   no lost or duplicated responses, and all data matches the model.

Source files
------------

// File: rtl/reg_file_slave.sv
// reg_file_slave: register-bank responder for the reg_if protocol.
// Independent write and read channels, each with one outstanding transaction.
module reg_file_slave #(
  parameter int unsigned            ADDR_WIDTH  = 5,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            NUM_REGS    = 32,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0,
  parameter logic [NUM_REGS-1:0]    RO_MASK     = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic                           wvalid,
  output logic                           wready,
  input  logic                           bready,
  output logic [DATA_WIDTH-1:0]          bdata,
  output logic                           bvalid,
  input  logic [ADDR_WIDTH-1:0]          raddr,
  input  logic                           arvalid,
  output logic                           aready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  typedef enum logic { W_IDLE, W_RESP } wstate_t;
  typedef enum logic { R_IDLE, R_RESP } rstate_t;

  wstate_t               wstate_q;
  rstate_t               rstate_q;
  logic                  wready_q, bvalid_q, aready_q, rvalid_q;
  logic [DATA_WIDTH-1:0] bdata_q, rdata_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  w_hs;
  logic                  w_hit, w_ro;
  logic [DATA_WIDTH-1:0] w_cur, w_post_d, r_cur_d;

  assign w_hs = wvalid & wready_q;

  // Address decode: an address matching no implemented register is unmapped and reads as zero.
  always_comb begin
    w_hit   = 1'b0;
    w_ro    = 1'b0;
    w_cur   = '0;
    r_cur_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (waddr == ADDR_WIDTH'(i)) begin
        w_hit = 1'b1;
        w_ro  = RO_MASK[i];
        w_cur = regs_q[i];
      end
      if (raddr == ADDR_WIDTH'(i)) begin
        r_cur_d = regs_q[i];
      end
    end
    w_post_d = w_hit ? (w_ro ? w_cur : wdata) : '0;
  end

  // Register storage; reads sample regs_q before this update, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
    end else if (w_hs) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (waddr == ADDR_WIDTH'(i) && !RO_MASK[i]) regs_q[i] <= wdata;
      end
    end
  end

  // Write channel FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q <= W_IDLE;
      wready_q <= 1'b1;
      bvalid_q <= 1'b0;
      bdata_q  <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: if (wvalid) begin
          wstate_q <= W_RESP;
          wready_q <= 1'b0;
          bvalid_q <= 1'b1;
          bdata_q  <= w_post_d;
        end
        W_RESP: if (bready) begin
          wstate_q <= W_IDLE;
          wready_q <= 1'b1;
          bvalid_q <= 1'b0;
        end
        default: begin
          wstate_q <= W_IDLE;
          wready_q <= 1'b1;
          bvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // Read channel FSM with registered handshake and data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q <= R_IDLE;
      aready_q <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: if (arvalid) begin
          rstate_q <= R_RESP;
          aready_q <= 1'b0;
          rvalid_q <= 1'b1;
          rdata_q  <= r_cur_d;
        end
        R_RESP: if (rready) begin
          rstate_q <= R_IDLE;
          aready_q <= 1'b1;
          rvalid_q <= 1'b0;
        end
        default: begin
          rstate_q <= R_IDLE;
          aready_q <= 1'b1;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // Flatten the register array for export.
  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  assign wready = wready_q;
  assign bvalid = bvalid_q;
  assign bdata  = bdata_q;
  assign aready = aready_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule
